// File: rtl/neopixel_fifo_reader.sv
// WS2812 serialiser: pops 24-bit pixels from a FWFT FIFO and sends them MSB-first, then latches.
// Optional NEOPIXEL_TX_INVERT_EN inverts pixel_o (idle/reset level becomes 1) for inverting level-shifters.
module neopixel_fifo_reader #(
   parameter int unsigned T0hCycles   = 8,
   parameter int unsigned T1hCycles   = 16,
   parameter int unsigned BitCycles   = 25,
   parameter int unsigned ResetCycles = 1000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        enable_i,
   input  logic        fifo_empty_i,
   input  logic [23:0] fifo_data_i,
   output logic        fifo_pop_o,
   output logic        pixel_o,
   output logic        busy_o,
   output logic        frame_done_o,
   output logic [4:0]  bit_cnt_o
);

   localparam int unsigned MaxCyc = (BitCycles > ResetCycles) ? BitCycles : ResetCycles;
   localparam int unsigned CycW   = $clog2(MaxCyc + 1);

`ifdef NEOPIXEL_TX_INVERT_EN
   localparam logic IdleLevel = 1'b1;
`else
   localparam logic IdleLevel = 1'b0;
`endif

   if (!(T0hCycles > 0 && T0hCycles < T1hCycles && T1hCycles < BitCycles &&
         ResetCycles >= BitCycles)) begin : g_param_check
      $fatal(1, "neopixel_fifo_reader: illegal timing parameters");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      LATCH = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [23:0]       sr_q, sr_d;
   logic [4:0]        bit_q, bit_d;
   logic [CycW-1:0]   cyc_q, cyc_d;
   logic              pixel_q, pixel_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pop_c, can_load_c, bit_end_c, high_c;

   // State and output registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         sr_q    <= '0;
         bit_q   <= '0;
         cyc_q   <= '0;
         pixel_q <= IdleLevel;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         bit_q   <= bit_d;
         cyc_q   <= cyc_d;
         pixel_q <= pixel_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic; outputs are registered from the next-state values
   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      bit_d      = bit_q;
      cyc_d      = cyc_q;
      pop_c      = 1'b0;
      done_d     = 1'b0;
      can_load_c = enable_i && !fifo_empty_i;
      bit_end_c  = (cyc_q == CycW'(BitCycles - 1));

      unique case (state_q)
         IDLE: begin
            if (can_load_c) begin
               pop_c   = 1'b1;
               sr_d    = fifo_data_i;
               bit_d   = 5'd23;
               cyc_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            cyc_d = cyc_q + CycW'(1);
            if (bit_end_c) begin
               cyc_d = '0;
               if (bit_q != 5'd0) begin
                  sr_d  = {sr_q[22:0], 1'b0};
                  bit_d = bit_q - 5'd1;
               end else if (can_load_c) begin
                  pop_c = 1'b1;
                  sr_d  = fifo_data_i;
                  bit_d = 5'd23;
               end else begin
                  state_d = LATCH;
               end
            end
         end
         LATCH: begin
            cyc_d = cyc_q + CycW'(1);
            if (cyc_q == CycW'(ResetCycles - 1)) begin
               cyc_d   = '0;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cyc_d   = '0;
            bit_d   = '0;
         end
      endcase

      busy_d  = (state_d != IDLE);
      high_c  = (state_d == SEND) &&
                (cyc_d < (sr_d[23] ? CycW'(T1hCycles) : CycW'(T0hCycles)));
      pixel_d = high_c ^ IdleLevel;
   end

   // Pop is a same-cycle strobe for the FWFT head; a concurrent flush simply wins at the FIFO.
   assign fifo_pop_o   = pop_c && !rst_i;
   assign pixel_o      = pixel_q;
   assign busy_o       = busy_q;
   assign frame_done_o = done_q;
   assign bit_cnt_o    = bit_q;

endmodule

// File: tb/tb_neopixel_fifo_reader.sv
// Self-checking bench for neopixel_fifo_reader: FIFO model plus a waveform model built from the pixel words.
module tb_neopixel_fifo_reader;

   localparam int unsigned T0   = 8;
   localparam int unsigned T1   = 16;
   localparam int unsigned BitC = 25;
   localparam int unsigned ResC = 1000;
   localparam int          PixC = 24 * BitC;
`ifdef NEOPIXEL_TX_INVERT_EN
   localparam logic Idle = 1'b1;
`else
   localparam logic Idle = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_i, enable_i, fifo_empty_i;
   logic [23:0] fifo_data_i;
   logic        fifo_pop_o, pixel_o, busy_o, frame_done_o;
   logic [4:0]  bit_cnt_o;

   int          vectors = 0;
   int          miscompares = 0;
   logic [23:0] fifo_q[$];
   logic [23:0] frame_words[$];
   logic [8:0]  obs_q[$];
   logic [8:0]  exp_q[$];
   int          pops_seen, first_bad, nbad;
   logic [8:0]  bad_obs, bad_exp;

   always #5 clk = ~clk;

   neopixel_fifo_reader #(
      .T0hCycles(T0), .T1hCycles(T1), .BitCycles(BitC), .ResetCycles(ResC)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .fifo_empty_i(fifo_empty_i),
      .fifo_data_i(fifo_data_i), .fifo_pop_o(fifo_pop_o), .pixel_o(pixel_o),
      .busy_o(busy_o), .frame_done_o(frame_done_o), .bit_cnt_o(bit_cnt_o)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void drive_fifo();
      fifo_empty_i = (fifo_q.size() == 0);
      fifo_data_i  = fifo_empty_i ? 24'h0 : fifo_q[0];
   endfunction

   // One clock: sample {pixel,pop,done,busy,bit_cnt} at negedge, apply the pop after the edge.
   task automatic sample_cycle(output logic [8:0] v);
      @(negedge clk);
      v = {pixel_o, fifo_pop_o, frame_done_o, busy_o, bit_cnt_o};
      @(posedge clk);
      #1;
      if (v[7] && fifo_q.size() > 0) void'(fifo_q.pop_front());
      drive_fifo();
   endtask

   // Capture one frame from the first high cycle (t=0) to the frame_done cycle.
   task automatic run_frame(input bit already_popped, input int drop_t, input int push_t,
                            input logic [23:0] push_w);
      logic [8:0] v;
      int last;
      last = frame_words.size() * PixC + ResC;
      obs_q.delete();
      pops_seen = already_popped ? 1 : 0;
      if (!already_popped) begin
         for (int i = 0; i < 50 && pops_seen == 0; i++) begin
            sample_cycle(v);
            if (v[7]) pops_seen = 1;
         end
         if (pops_seen == 0) return;
      end
      for (int t = 0; t <= last; t++) begin
         sample_cycle(v);
         obs_q.push_back(v);
         if (v[7]) pops_seen++;
         if (t == drop_t) enable_i = 1'b0;
         if (t == push_t) begin
            fifo_q.push_back(push_w);
            drive_fifo();
         end
      end
   endtask

   // Expected waveform straight from the pulse-width rules for each word of the frame.
   function automatic void build_expected(input bit pop_at_end);
      int   n;
      logic px, pop;
      n = frame_words.size();
      exp_q.delete();
      for (int k = 0; k < n; k++)
         for (int b = 23; b >= 0; b--)
            for (int c = 0; c < int'(BitC); c++) begin
               px  = (c < int'(frame_words[k][b] ? T1 : T0));
               pop = (b == 0 && c == int'(BitC) - 1 && k < n - 1);
               exp_q.push_back({px ^ Idle, pop, 1'b0, 1'b1, 5'(b)});
            end
      for (int c = 0; c < int'(ResC); c++) exp_q.push_back({Idle, 1'b0, 1'b0, 1'b1, 5'd0});
      exp_q.push_back({Idle, pop_at_end, 1'b1, 1'b0, 5'd0});
   endfunction

   function automatic int trace_diff();
      int len, bad;
      bad = 0;
      first_bad = -1;
      bad_obs = 'x;
      bad_exp = 'x;
      len = (obs_q.size() > exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int t = 0; t < len; t++) begin
         if (t >= obs_q.size() || t >= exp_q.size() || obs_q[t] !== exp_q[t]) begin
            if (first_bad < 0) begin
               first_bad = t;
               if (t < obs_q.size()) bad_obs = obs_q[t];
               if (t < exp_q.size()) bad_exp = exp_q[t];
            end
            bad++;
         end
      end
      return bad;
   endfunction

   task automatic test_reset();
      rst_i = 1'b1;
      #1;
      vectors++;
      if ({pixel_o, fifo_pop_o, frame_done_o, busy_o, bit_cnt_o} !== {Idle, 8'h00}) begin
         miscompares++;
         $display("FAIL reset_values: got %b required %b",
                  {pixel_o, fifo_pop_o, frame_done_o, busy_o, bit_cnt_o}, {Idle, 8'h00});
      end
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;
   endtask

   task automatic test_idle_empty();
      logic [8:0] v;
      int bad = 0;
      enable_i = 1'b1;
      drive_fifo();
      for (int i = 0; i < 100; i++) begin
         sample_cycle(v);
         if (v !== {Idle, 8'h00}) bad++;
      end
      vectors++;
      if (bad !== 0) begin
         miscompares++;
         $display("FAIL idle_empty: %0d cycles off idle, last got %b required %b", bad, v, {Idle, 8'h00});
      end
   endtask

   task automatic test_single_word();
      frame_words = '{24'h800001};
      fifo_q.push_back(24'h800001);
      drive_fifo();
      run_frame(1'b0, -1, -1, 24'h0);
      build_expected(1'b0);
      nbad = trace_diff();
      vectors++;
      if (nbad !== 0) begin
         miscompares++;
         $display("FAIL single_trace: %0d bad cycles, first t=%0d got %b required %b", nbad, first_bad, bad_obs, bad_exp);
      end
      vectors++;
      if (pops_seen !== 1) begin
         miscompares++;
         $display("FAIL single_pops: got %0d required 1", pops_seen);
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0] v;
      int pops = 0;
      enable_i = 1'b0;
      fifo_q.push_back(24'hFFFFFF);
      fifo_q.push_back(24'h000000);
      drive_fifo();
      for (int i = 0; i < 5; i++) begin
         sample_cycle(v);
         if (v[7]) pops++;
      end
      vectors++;
      if (pops !== 0) begin
         miscompares++;
         $display("FAIL disabled_pop: got %0d pops required 0", pops);
      end
      enable_i = 1'b1;
      frame_words = '{24'hFFFFFF, 24'h000000};
      run_frame(1'b0, -1, -1, 24'h0);
      build_expected(1'b0);
      nbad = trace_diff();
      vectors++;
      if (nbad !== 0) begin
         miscompares++;
         $display("FAIL b2b_trace: %0d bad cycles, first t=%0d got %b required %b", nbad, first_bad, bad_obs, bad_exp);
      end
      vectors++;
      if (pops_seen !== 2) begin
         miscompares++;
         $display("FAIL b2b_pops: got %0d required 2", pops_seen);
      end
   endtask

   task automatic test_enable_drop();
      logic [23:0] w[3];
      for (int i = 0; i < 3; i++) begin
         w[i] = 24'($urandom);
         fifo_q.push_back(w[i]);
      end
      drive_fifo();
      frame_words = '{w[0]};
      run_frame(1'b0, 11 * BitC, -1, 24'h0);
      build_expected(1'b0);
      nbad = trace_diff();
      vectors++;
      if (nbad !== 0) begin
         miscompares++;
         $display("FAIL drop_trace: %0d bad cycles, first t=%0d got %b required %b", nbad, first_bad, bad_obs, bad_exp);
      end
      vectors++;
      if (fifo_q.size() !== 2) begin
         miscompares++;
         $display("FAIL drop_fifo_left: got %0d words required 2", fifo_q.size());
      end
      fifo_q.delete();
      drive_fifo();
      enable_i = 1'b1;
   endtask

   task automatic test_latch_push();
      logic [23:0] w0, w1;
      w0 = 24'($urandom);
      w1 = 24'($urandom);
      fifo_q.push_back(w0);
      drive_fifo();
      frame_words = '{w0};
      run_frame(1'b0, -1, PixC + 500, w1);
      build_expected(1'b1);
      nbad = trace_diff();
      vectors++;
      if (nbad !== 0) begin
         miscompares++;
         $display("FAIL latch_push_trace: %0d bad cycles, first t=%0d got %b required %b", nbad, first_bad, bad_obs, bad_exp);
      end
      vectors++;
      if (pops_seen !== 2) begin
         miscompares++;
         $display("FAIL latch_push_pops: got %0d required 2", pops_seen);
      end
      frame_words = '{w1};
      run_frame(1'b1, -1, -1, 24'h0);
      build_expected(1'b0);
      nbad = trace_diff();
      vectors++;
      if (nbad !== 0) begin
         miscompares++;
         $display("FAIL latch_next_trace: %0d bad cycles, first t=%0d got %b required %b", nbad, first_bad, bad_obs, bad_exp);
      end
   endtask

   task automatic test_reset_mid_pixel();
      logic [8:0]  v;
      logic [23:0] w0, w1;
      bit found = 1'b0;
      w0 = 24'($urandom);
      w1 = 24'($urandom);
      fifo_q.push_back(w0);
      fifo_q.push_back(w1);
      drive_fifo();
      for (int i = 0; i < 700 && !found; i++) begin
         sample_cycle(v);
         if (v[4:0] == 5'd10 && (v[8] ^ Idle) && v[5]) found = 1'b1;
      end
      vectors++;
      if (found !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_reach_bit10: got %b required 1", found);
      end
      rst_i = 1'b1;
      #1;
      vectors++;
      if ({pixel_o, busy_o, fifo_pop_o, frame_done_o, bit_cnt_o} !== {Idle, 8'h00}) begin
         miscompares++;
         $display("FAIL reset_async: got %b required %b",
                  {pixel_o, busy_o, fifo_pop_o, frame_done_o, bit_cnt_o}, {Idle, 8'h00});
      end
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;
      frame_words = '{w1};
      run_frame(1'b0, -1, -1, 24'h0);
      build_expected(1'b0);
      nbad = trace_diff();
      vectors++;
      if (nbad !== 0) begin
         miscompares++;
         $display("FAIL reset_next_trace: %0d bad cycles, first t=%0d got %b required %b", nbad, first_bad, bad_obs, bad_exp);
      end
   endtask

   task automatic test_random_frames();
      logic [23:0] w;
      int n;
      for (int r = 0; r < 4; r++) begin
         n = int'($urandom_range(3, 1));
         frame_words.delete();
         for (int i = 0; i < n; i++) begin
            w = 24'($urandom);
            frame_words.push_back(w);
            fifo_q.push_back(w);
         end
         drive_fifo();
         run_frame(1'b0, -1, -1, 24'h0);
         build_expected(1'b0);
         nbad = trace_diff();
         vectors++;
         if (nbad !== 0 || pops_seen !== n) begin
            miscompares++;
            $display("FAIL random_frame%0d: %0d bad cycles (first t=%0d got %b required %b), pops %0d required %0d",
                     r, nbad, first_bad, bad_obs, bad_exp, pops_seen, n);
         end
      end
   endtask

   initial begin
      rst_i    = 1'b1;
      enable_i = 1'b0;
      drive_fifo();
      test_reset();
      test_idle_empty();
      test_single_word();
      test_back_to_back();
      test_enable_drop();
      test_latch_push();
      test_reset_mid_pixel();
      test_random_frames();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/neopixel_fifo_reader.md
Name: neopixel_fifo_reader

Overview:
- Consumer end of the NeoPixel colour FIFO.
- Pops 24-bit pixel words from the FIFO whenever it is non-empty and enabled.
- Serialises each word MSB-first onto the single-wire WS2812 line using cycle-counted high/low pulse widths.
- After the FIFO drains, holds the line low for a latch interval and then signals end of frame. Sits between the colour FIFO (first-word-fall-through) and the pad driver.

Parameters:
- T0hCycles, 8, cycles the line is high for a '0' bit (0.4 us at 20 MHz).
- T1hCycles, 16, cycles the line is high for a '1' bit (0.8 us at 20 MHz).
- BitCycles, 25, total cycles per bit (1.25 us at 20 MHz).
- ResetCycles, 1000, cycles of low after the last pixel of a frame (50 us at 20 MHz).
- Legal ranges: 0 < T0hCycles < T1hCycles < BitCycles; ResetCycles >= BitCycles. Out-of-range values are a $fatal at elaboration.

Ports:
- clk_i  input  1  Primary clock. Single clock domain.
- rst_i  input  1  Asynchronous, active-high reset.
- enable_i  input  1  Allows new frames and new pixels to start.
- fifo_empty_i  input  1  FIFO empty flag.
- fifo_data_i  input  24  FIFO head word; valid whenever fifo_empty_i=0.
- fifo_pop_o  output  1  One-cycle pop strobe; consumes the head word.
- pixel_o  output  1  Serial WS2812 data line.
- busy_o  output  1  High whenever the FSM is not in IDLE.
- frame_done_o  output  1  One-cycle pulse when LATCH completes.
- bit_cnt_o  output  5  Index of the bit being sent (23..0); 0 in IDLE/LATCH.

Behaviour:
- Reset (asynchronous, immediate):
  - FSM = IDLE; counters and shift register = 0.
  - pixel_o=0, fifo_pop_o=0, busy_o=0, frame_done_o=0, bit_cnt_o=0.
  - Reset asserted mid-pixel aborts the pixel at once; the partial word is lost.
- Registers:
  - 24-bit shift register sr.
  - 5-bit bit counter.
  - Cycle counter, width $clog2(max(BitCycles,ResetCycles)+1).
- IDLE:
  - If enable_i=1 and fifo_empty_i=0: assert fifo_pop_o this cycle, load sr=fifo_data_i, set bit=23, cyc=0, go to SEND.
  - Otherwise stay in IDLE.
- SEND:
  - pixel_o=1 while cyc < (sr[23] ? T1hCycles : T0hCycles), else 0. pixel_o is registered.
  - cyc increments each cycle.
  - At cyc==BitCycles-1, with bit>0: shift sr left by 1, bit decrements, cyc=0.
  - At cyc==BitCycles-1, with bit==0 (last cycle of the pixel):
    - If enable_i=1 and fifo_empty_i=0: pop and reload sr in this cycle, bit=23, cyc=0, stay in SEND. There is no gap cycle between pixels.
    - Otherwise: cyc=0, go to LATCH.
  - enable_i deasserting mid-pixel does not truncate the pixel; it only blocks the reload at the pixel boundary.
  - fifo_pop_o is asserted only in the cycle sr is loaded; it is never asserted while fifo_empty_i=1.
- LATCH:
  - pixel_o=0; cyc increments.
  - At cyc==ResetCycles-1: pulse frame_done_o, go to IDLE.
  - Data arriving during LATCH is not popped until IDLE, so a new frame never starts inside the latch window.
- Latency: the first rising edge of pixel_o comes 1 cycle after the pop cycle.
- Pop/flush in the same cycle: the producer's FIFO flush takes priority. The reader treats the captured word as already consumed.

Optional Feature:
- Macro: NEOPIXEL_TX_INVERT_EN.
- Defined: pixel_o is the logical inverse of the waveform above, including reset and IDLE/LATCH values (pixel_o=1). This supports an inverting level-shifter. All timing is unchanged.
- Undefined: pixel_o is driven non-inverted as specified.

Test Plan:
- Reset then FIFO empty, enable_i=1 for 100 cycles:
  - fifo_pop_o never asserted.
  - pixel_o=0 and busy_o=0 throughout.
- Single word 24'h800001 with default parameters:
  - Exactly one pop.
  - Bit 23: high 16 cycles, low 9.
  - Bits 22..1: high 8, low 17.
  - Bit 0: high 16, low 9.
  - Then low for 1000 cycles.
  - frame_done_o pulses exactly 1 cycle, 600+1000 cycles after the first rising edge.
- Two words 24'hFFFFFF, 24'h000000 preloaded:
  - Second pop occurs on the last cycle of bit 0 of the first word.
  - 48 consecutive bit periods of 25 cycles with no gap.
  - Only one LATCH, and one frame_done_o.
- enable_i dropped at bit 12 of the first of three queued words:
  - First pixel completes all 24 bits.
  - No further pop; LATCH follows; 2 words remain in the FIFO.
- Word pushed during LATCH (cycle 500):
  - No pop until frame_done_o.
  - Pop occurs in the IDLE cycle after frame_done_o.
- rst_i asserted at bit 10 of a pixel:
  - pixel_o=0 and busy_o=0 in the same cycle (asynchronous).
  - After release, the next queued word is sent from bit 23.
  - With NEOPIXEL_TX_INVERT_EN defined, pixel_o=1 under reset instead.
